ap_ctrl_seq_driver: RTL

- Synthesizable initiator for the HLS ap_ctrl_chain block-level handshake: ap_start, ap_ready, ap_done, ap_continue.
- Launches a programmed number of back-to-back transactions into a kernel such as the ECC encoder, with a configurable idle gap between transactions.
- Measures per-transaction latency and total run time, then signals finish.
- Sits on the driving side of the handshake that the dataflow/loop monitors observe, and also serves as an on-board stimulus source.

---
 rtl/ap_ctrl_seq_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_seq_driver.sv
// rtl/ap_ctrl_seq_driver.sv - ap_ctrl_chain initiator: runs N kernel transactions, measures latency.
// Optional watchdog: define AP_CTRL_SEQ_DRIVER_TIMEOUT_EN.
module ap_ctrl_seq_driver #(
  parameter int CNT_W       = 32,
  parameter int NUM_W       = 16,
  parameter int GAP_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [NUM_W-1:0] cfg_num_txn,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [NUM_W-1:0] txn_count,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic [CNT_W-1:0] total_cycles,
  output logic             timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [NUM_W-1:0] num_r;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] lat;
  logic [NUM_W-1:0] txn_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign busy     = (state != S_IDLE);
  assign txn_next = txn_count + NUM_W'(1);

`ifdef AP_CTRL_SEQ_DRIVER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      num_r        <= '0;
      gap_r        <= '0;
      gap_cnt      <= '0;
      lat          <= '0;
      ap_start     <= 1'b0;
      ap_continue  <= 1'b0;
      finish       <= 1'b0;
      txn_count    <= '0;
      last_latency <= '0;
      max_latency  <= '0;
      total_cycles <= '0;
`ifdef AP_CTRL_SEQ_DRIVER_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            num_r        <= cfg_num_txn;
            gap_r        <= cfg_gap;
            txn_count    <= '0;
            last_latency <= '0;
            max_latency  <= '0;
            total_cycles <= '0;
`ifdef AP_CTRL_SEQ_DRIVER_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            if (cfg_num_txn == '0) begin
              state  <= S_FIN;
              finish <= 1'b1;
            end else begin
              state    <= S_START;
              ap_start <= 1'b1;
              lat      <= '0;
            end
          end
        end
        S_START, S_WAIT: begin
          total_cycles <= sat_inc(total_cycles);
          lat          <= sat_inc(lat);
`ifdef AP_CTRL_SEQ_DRIVER_TIMEOUT_EN
          if (lat == TIMEOUT_LIM) begin
            timeout_err <= 1'b1;
            ap_start    <= 1'b0;
            ap_continue <= 1'b0;
            state       <= S_FIN;
            finish      <= 1'b1;
          end else
`endif
          // done while still in START counts as ready+done in the same cycle
          if (ap_done) begin
            last_latency <= lat;
            if (lat > max_latency) max_latency <= lat;
            txn_count <= txn_next;
            if (txn_next == num_r) begin
              state       <= S_FIN;
              finish      <= 1'b1;
              ap_start    <= 1'b0;
              ap_continue <= 1'b0;
            end else if (gap_r == '0) begin
              state       <= S_START;
              ap_start    <= 1'b1;
              ap_continue <= 1'b0;
              lat         <= '0;
            end else begin
              state       <= S_GAP;
              gap_cnt     <= gap_r - GAP_W'(1);
              ap_start    <= 1'b0;
              ap_continue <= 1'b0;
            end
          end else if (state == S_START && ap_ready) begin
            state       <= S_WAIT;
            ap_start    <= 1'b0;
            ap_continue <= 1'b1;
          end
        end
        S_GAP: begin
          total_cycles <= sat_inc(total_cycles);
          if (gap_cnt == '0) begin
            state    <= S_START;
            ap_start <= 1'b1;
            lat      <= '0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_FIN: begin
          total_cycles <= sat_inc(total_cycles);
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
